prog_mem_loader: RTL

Program memory and boot loader feeding the microprocessor's instruction/data input. Accepts a program as a stream of 16-bit words over a valid/ready handshake, stores it in a 128×16 array, then releases the processor and serves combinational reads on the processor's 7-bit address bus. Sits directly upstream of the processor: its `d_in` drives the processor's `d_in`, and its `run` drives the processor's active-low `reset`.

---
 rtl/prog_mem_loader_if.sv | 24 ++
 rtl/prog_mem_loader.sv | 93 +++++++++
 2 files changed

// File: rtl/prog_mem_loader_if.sv
// Program-word stream from the boot source into the program memory.
// The master presents words; the slave (prog_mem_loader) answers with ld_ready.
interface prog_mem_loader_if #(
    parameter int DW = 16
);
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Program memory with boot loader: fills a DEPTH x DW array from a word stream,
// then holds the processor's run enable and serves zero-latency reads on addr.
module prog_mem_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 16
) (
    input  logic                clk,
    input  logic                reset,
    prog_mem_loader_if.slave    ld,
    input  logic                reload,
    input  logic [AW-1:0]       addr,
    output logic [DW-1:0]       d_in,
    output logic                run,
    output logic [AW:0]         count
);

    typedef enum logic {LOAD, RUN} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   wptr_reg, wptr_next;
    logic [AW:0]     count_reg, count_next;
    logic [DEPTH-1:0] valid_reg;
    logic [DW-1:0]   mem [DEPTH];
    logic            accept;
    logic            clear_valid;

    assign ld.ld_ready = (state_reg == LOAD);
    assign run         = (state_reg == RUN);
    assign count       = count_reg;

    always_comb begin
        state_next  = state_reg;
        wptr_next   = wptr_reg;
        count_next  = count_reg;
        accept      = 1'b0;
        clear_valid = 1'b0;
        case (state_reg)
            LOAD: begin
                if (ld.ld_valid) begin
                    accept    = 1'b1;
                    wptr_next = wptr_reg + 1'b1;
                    if (count_reg != (AW+1)'(DEPTH))
                        count_next = count_reg + 1'b1;
                    // The wrap of wptr always coincides with leaving LOAD.
                    if (ld.ld_last || wptr_reg == AW'(DEPTH - 1))
                        state_next = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_next  = LOAD;
                    wptr_next   = '0;
                    count_next  = '0;
                    clear_valid = 1'b1;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= LOAD;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            wptr_reg  <= wptr_next;
            count_reg <= count_next;
        end
    end

    // Contents survive reload; only the valid bits gate what the processor sees.
    always_ff @(posedge clk) begin
        if (reset && accept)
            mem[wptr_reg] <= ld.ld_data;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (!reset || clear_valid)
                    valid_reg[gi] <= 1'b0;
                else if (accept && wptr_reg == AW'(gi))
                    valid_reg[gi] <= 1'b1;
            end
        end
    endgenerate

    assign d_in = valid_reg[addr] ? mem[addr] : '0;

endmodule
